// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory responder.
package mem_pkg;

    localparam int unsigned DEPTH_DEFAULT = 64;
    localparam int unsigned WAIT_DEFAULT  = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/ram_array.sv
// Word storage: synchronous write, combinational read, no reset on contents.
module ram_array #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IdxW  = 6
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [IdxW-1:0] addr_i,
    input  logic [31:0]     wdata_i,
    output logic [31:0]     rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accept, wait a fixed latency, then hold
// a registered response until the initiator takes it.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_DEFAULT,
    parameter int unsigned DEPTH       = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q;
    logic [31:0]     addr_q, wdata_q;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q;
    logic            commit;
    logic            cur_we, cur_err;
    logic [31:0]     cur_addr, cur_wdata;
    logic [IdxW-1:0] cur_idx;
    logic [31:0]     ram_rdata;

    // With zero wait the commit happens on the accept edge, before capture.
    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
        cur_err = (cur_addr[1:0] != 2'b00) || ({2'b00, cur_addr[31:2]} >= DEPTH);
        cur_idx = cur_addr[IdxW+1:2];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rdata_d = (!cur_we && !cur_err) ? ram_rdata : 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && req_valid) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (commit) begin
                rdata_q <= rdata_d;
                err_q   <= cur_err;
            end
        end
    end

    ram_array #(
        .DEPTH(DEPTH),
        .IdxW (IdxW)
    ) u_ram (
        .clk_i  (clk),
        .we_i   (commit && cur_we && !cur_err),
        .addr_i (cur_idx),
        .wdata_i(cur_wdata),
        .rdata_o(ram_rdata)
    );

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
